// File: rtl/mem_req_arbiter_pkg.sv
// Shared source ids, size encodings and lock states for the memory request arbiter.
package mem_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/mem_req_arbiter_src_id_fifo.sv
// In-order record of which requester issued each accepted, still-unanswered request.
module src_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] ids_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = ids_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ids_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between fetch and EX, holding a waiting request stable
// and steering in-order responses back to whoever issued them.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  lock_state_e   lock_q, lock_d;
  logic          lock_src_q, lock_src_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_vld, owner, lock_hold;
  logic          fifo_full, fifo_empty, fifo_head, push;

  // A locked requester that drops its request releases the port in that same cycle.
  assign lock_hold = (lock_q == LOCKED) &&
                     (lock_src_q == SRC_DATA ? data_sram_req : inst_sram_req);

  always_comb begin
    owner_vld = 1'b1;
    owner     = SRC_DATA;
    if (lock_hold)                                    owner = lock_src_q;
    else if (starve_q == SW'(STARVE_LIMIT) && inst_sram_req) owner = SRC_INST;
    else if (data_sram_req)                           owner = SRC_DATA;
    else if (inst_sram_req)                           owner = SRC_INST;
    else                                              owner_vld = 1'b0;
  end

  always_comb begin
    mem_req   = owner_vld & ~fifo_full;
    mem_wr    = 1'b0;
    mem_size  = SIZE_WORD;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!owner_vld) begin
      mem_size = SIZE_BYTE;
    end else if (owner == SRC_DATA) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else begin
      mem_addr = inst_sram_addr;
    end
  end

  assign push              = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = push & (owner == SRC_INST);
  assign data_sram_addr_ok = push & (owner == SRC_DATA);

  assign inst_sram_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == SRC_INST);
  assign data_sram_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_comb begin
    lock_d     = UNLOCKED;
    lock_src_d = lock_src_q;
    if (mem_req && !mem_addr_ok) begin
      lock_d     = LOCKED;
      lock_src_d = owner;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!inst_sram_req || (push && owner == SRC_INST))
      starve_d = '0;
    else if (push && owner == SRC_DATA && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= UNLOCKED;
      lock_src_q <= SRC_INST;
      starve_q   <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
    end
  end

  src_id_fifo #(.DEPTH(DEPTH)) u_src_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (mem_data_ok),
    .din_i   (owner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a queue-based reference model checked every cycle.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // Reference model: queue of issuers awaiting a response, the offered-but-unaccepted
  // request (if any), and the count of data grants made while fetch waited.
  bit m_q[$];
  bit m_pend;
  bit m_psrc;      // 0 = fetch, 1 = EX
  int m_starve;
  bit chk_en = 1'b0;

  always @(negedge clk) begin : model
    bit gv, gs, e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok, hs;
    logic [1:0]   e_size;
    logic [3:0]   e_wstrb;
    logic [31:0]  e_addr, e_wdata;
    logic [139:0] act, expv;
    gv = 1'b1; gs = 1'b1;
    if (m_pend && (m_psrc ? data_sram_req : inst_sram_req)) gs = m_psrc;
    else if (m_starve >= 8 && inst_sram_req)                gs = 1'b0;
    else if (data_sram_req)                                 gs = 1'b1;
    else if (inst_sram_req)                                 gs = 1'b0;
    else                                                    gv = 1'b0;
    e_req = gv && (m_q.size() < 4);
    e_wr = 1'b0; e_size = 2'b00; e_wstrb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    if (gv && gs) begin
      e_wr = data_sram_wr; e_size = data_sram_size; e_wstrb = data_sram_wstrb;
      e_addr = data_sram_addr; e_wdata = data_sram_wdata;
    end else if (gv) begin
      e_size = 2'b10; e_addr = inst_sram_addr;
    end
    hs     = e_req && mem_addr_ok;
    e_iaok = hs && !gs;
    e_daok = hs && gs;
    e_idok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == 1'b0);
    e_ddok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == 1'b1);
    act  = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
            inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
            data_sram_addr_ok, data_sram_data_ok, data_sram_rdata};
    expv = {e_req, e_wr, e_size, e_wstrb, e_addr, e_wdata,
            e_iaok, e_idok, mem_rdata, e_daok, e_ddok, mem_rdata};
    if (chk_en) begin
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, expv);
      end
    end
    if (reset) begin
      m_q.delete(); m_pend = 1'b0; m_psrc = 1'b0; m_starve = 0;
    end else begin
      if (mem_data_ok && m_q.size() > 0) void'(m_q.pop_front());
      if (hs) m_q.push_back(gs);
      m_pend = e_req && !mem_addr_ok;
      m_psrc = gs;
      if (!inst_sram_req || (hs && !gs)) m_starve = 0;
      else if (hs && gs && m_starve < 8)  m_starve++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    inst_sram_req = 1'b0; inst_sram_addr = 32'h0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'b10;
    data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic drain();
    idle();
    mem_data_ok = 1'b1;
    repeat (6) nxt();
    mem_data_ok = 1'b0;
    nxt();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    nxt(); nxt();
    reset  = 1'b0;
    chk_en = 1'b1;
    settle();
    chk("reset_mem_req", mem_req, 0);
    chk("reset_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    chk("reset_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);

    // Simultaneous requests: EX first, then fetch; responses return in that order.
    nxt();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000;
    data_sram_req = 1'b1; data_sram_addr = 32'h00001000; mem_addr_ok = 1'b1;
    settle();
    chk("t1_c0_addr", mem_addr, 32'h00001000);
    chk("t1_c0_daok", data_sram_addr_ok, 1);
    chk("t1_c0_iaok", inst_sram_addr_ok, 0);
    nxt(); data_sram_req = 1'b0;
    settle();
    chk("t1_c1_addr", mem_addr, 32'h1c000000);
    chk("t1_c1_iaok", inst_sram_addr_ok, 1);
    nxt(); inst_sram_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'haaaa5555;
    settle();
    chk("t1_r0_ddok", data_sram_data_ok, 1);
    chk("t1_r0_idok", inst_sram_data_ok, 0);
    chk("t1_r0_drdata", data_sram_rdata, 32'haaaa5555);
    nxt(); mem_rdata = 32'h12345678;
    settle();
    chk("t1_r1_idok", inst_sram_data_ok, 1);
    chk("t1_r1_irdata", inst_sram_rdata, 32'h12345678);
    drain();

    // Store held stable while waiting for acceptance; fetch rises meanwhile.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'b10;
    data_sram_wstrb = 4'hf; data_sram_addr = 32'h2004; data_sram_wdata = 32'hdeadbeef;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_addr_stable", mem_addr, 32'h2004);
      chk("t2_wstrb_stable", mem_wstrb, 4'hf);
      chk("t2_iaok_blocked", inst_sram_addr_ok, 0);
      nxt();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000040;
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_accept_daok", data_sram_addr_ok, 1);
    nxt(); data_sram_req = 1'b0;
    settle();
    chk("t2_inst_next_iaok", inst_sram_addr_ok, 1);
    nxt();
    drain();

    // Outstanding limit.
    data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_sram_addr = 32'h5000 + 32'(i * 4);
      settle();
      chk("t3_fill_daok", data_sram_addr_ok, 1);
      nxt();
    end
    mem_data_ok = 1'b1;
    settle();
    chk("t3_full_mem_req", mem_req, 0);
    chk("t3_full_daok", data_sram_addr_ok, 0);
    nxt(); mem_data_ok = 1'b0;
    settle();
    chk("t3_after_pop_mem_req", mem_req, 1);
    nxt();
    drain();

    // Starvation bound: eight EX grants, then fetch, then EX again.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000100;
    data_sram_req = 1'b1; data_sram_addr = 32'h4000; mem_addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (k == 8) chk("t4_hs9_inst", inst_sram_addr_ok, 1);
      else        chk("t4_hs_data", data_sram_addr_ok, 1);
      nxt();
      mem_data_ok = 1'b1;
    end
    drain();

    // EX flush while locked releases the port to fetch in the same cycle.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000200;
    data_sram_req = 1'b1; data_sram_addr = 32'h3000;
    settle();
    chk("t5_locked_addr", mem_addr, 32'h3000);
    nxt(); data_sram_req = 1'b0; mem_addr_ok = 1'b1;
    settle();
    chk("t5_flush_iaok", inst_sram_addr_ok, 1);
    chk("t5_flush_addr", mem_addr, 32'h1c000200);
    nxt(); idle(); mem_data_ok = 1'b1;
    settle();
    chk("t5_only_inst_idok", inst_sram_data_ok, 1);
    nxt();
    drain();

    // Reset with responses in flight abandons them.
    data_sram_req = 1'b1; data_sram_addr = 32'h6000; mem_addr_ok = 1'b1;
    nxt(); nxt();
    idle(); reset = 1'b1;
    nxt(); reset = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("t6_no_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("t6_mem_req", mem_req, 0);
    nxt(); idle();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
